uart_rx_fifo: RTL and testbench

Receive-side buffer placed directly downstream of the UART receiver. Captures every completed character, together with its parity, frame and break status, on the receiver's one-cycle data-ready strobe. Presents the characters to the register/bus interface through a first-word-fall-through valid/ready port. Also provides the level, overrun and character-timeout status used for UART interrupts.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_fifo_ram.sv | 24 ++
 rtl/uart_rx_fifo.sv | 110 +++++++++++
 tb/tb_uart_rx_fifo.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: receive-entry layout and default FIFO sizing.
// Used by the RX FIFO today and intended for the TX path later.
package uart_pkg;

  localparam int RX_ENTRY_W  = 11;
  localparam int RX_DATA_LSB = 0;
  localparam int RX_PAR_BIT  = 8;
  localparam int RX_FRM_BIT  = 9;
  localparam int RX_BRK_BIT  = 10;

  localparam int RX_FIFO_DEPTH    = 16;
  localparam int RX_TIMEOUT_TICKS = 160;

  function automatic logic [RX_ENTRY_W-1:0] rx_pack(
    input logic [7:0] data,
    input logic       par,
    input logic       frm,
    input logic       brk
  );
    logic [RX_ENTRY_W-1:0] e;
    e                          = '0;
    e[RX_DATA_LSB +: 8]        = data;
    e[RX_PAR_BIT]              = par;
    e[RX_FRM_BIT]              = frm;
    e[RX_BRK_BIT]              = brk;
    return e;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x WIDTH register file: synchronous write, asynchronous read, no reset.
// Shared storage primitive for the UART RX and TX FIFOs.
module uart_fifo_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 11,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: first-word-fall-through character buffer with level,
// sticky overrun and character-timeout status for interrupt generation.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH         = RX_FIFO_DEPTH,
  parameter  int TIMEOUT_TICKS = RX_TIMEOUT_TICKS,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sample_tick,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        wr_parity_err,
  input  logic        wr_frame_err,
  input  logic        wr_break_err,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [7:0]  rd_data,
  output logic        rd_parity_err,
  output logic        rd_frame_err,
  output logic        rd_break_err,
  input  logic        flush,
  input  logic        clr_overrun,
  input  logic [AW:0] thresh,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty,
  output logic        overrun,
  output logic        level_irq,
  output logic        timeout_irq
);

  localparam int            TW       = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_TICKS);

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [TW-1:0]         to_cnt;
  logic                  push, pop, drop;
  logic [RX_ENTRY_W-1:0] wr_entry, rd_entry;

  assign empty     = (level == '0);
  assign full      = (level == LVL_FULL);
  assign rd_valid  = !empty;
  assign level_irq = (thresh != '0) && (level >= thresh);

  // flush masks both ports; a full FIFO still accepts a push when a pop frees a slot
  assign pop  = rd_valid && rd_ready && !flush;
  assign push = wr_en && !flush && (!full || pop);
  assign drop = wr_en && !flush && full && !pop;

  assign wr_entry = rx_pack(wr_data, wr_parity_err, wr_frame_err, wr_break_err);

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RX_ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign rd_data       = rd_entry[RX_DATA_LSB +: 8];
  assign rd_parity_err = rd_entry[RX_PAR_BIT];
  assign rd_frame_err  = rd_entry[RX_FRM_BIT];
  assign rd_break_err  = rd_entry[RX_BRK_BIT];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // overrun survives flush; a drop in the same cycle as the clear wins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt      <= '0;
      timeout_irq <= 1'b0;
    end else if (flush || push || pop || empty) begin
      to_cnt <= '0;
      if (flush || pop) timeout_irq <= 1'b0;
    end else if (sample_tick && (to_cnt != TO_MAX)) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TO_MAX - 1'b1) timeout_irq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queue-based reference model, directed
// scenarios followed by randomized traffic, monitor compares on every negedge.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int TO    = 160;

  logic       clk = 1'b0;
  logic       resetn;
  logic       sample_tick, wr_en, wr_parity_err, wr_frame_err, wr_break_err;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, rd_ready, rd_parity_err, rd_frame_err, rd_break_err;
  logic       flush, clr_overrun;
  logic [4:0] thresh, level;
  logic       full, empty, overrun, level_irq, timeout_irq;

  uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .resetn(resetn), .sample_tick(sample_tick),
    .wr_en(wr_en), .wr_data(wr_data), .wr_parity_err(wr_parity_err),
    .wr_frame_err(wr_frame_err), .wr_break_err(wr_break_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err),
    .rd_break_err(rd_break_err), .flush(flush), .clr_overrun(clr_overrun),
    .thresh(thresh), .level(level), .full(full), .empty(empty),
    .overrun(overrun), .level_irq(level_irq), .timeout_irq(timeout_irq)
  );

  always #5 clk = ~clk;

  // reference model: contents as a queue of {brk,frm,par,data}, plus status
  logic [10:0] sb[$];
  logic        ovr_m = 1'b0;
  logic        to_m  = 1'b0;
  int          idle  = 0;
  int          checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    int          sz;
    logic [10:0] exp_e;
    sz = sb.size();
    chk("level", 32'(level), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("rd_valid", 32'(rd_valid), 32'(sz > 0));
    chk("overrun", 32'(overrun), 32'(ovr_m));
    chk("level_irq", 32'(level_irq), 32'((thresh != 0) && (sz >= int'(thresh))));
    chk("timeout_irq", 32'(timeout_irq), 32'(to_m));
    if (resetn && sz > 0 && rd_ready && !flush) begin
      exp_e = sb.pop_front();
      chk("rd_entry", 32'({rd_break_err, rd_frame_err, rd_parity_err, rd_data}), 32'(exp_e));
    end
  end

  task automatic step(input logic we, input logic [7:0] d, input logic [2:0] fl,
                      input logic rr, input logic tk,
                      input logic fsh = 1'b0, input logic clr = 1'b0);
    int   sz;
    logic pop_m, push_m, drop_m;
    wr_en = we; wr_data = d; {wr_break_err, wr_frame_err, wr_parity_err} = fl;
    rd_ready = rr; sample_tick = tk; flush = fsh; clr_overrun = clr;
    sz     = sb.size();
    pop_m  = (sz > 0) && rr && !fsh;
    push_m = we && !fsh && ((sz < DEPTH) || pop_m);
    drop_m = we && !fsh && (sz == DEPTH) && !pop_m;
    @(posedge clk);
    if (fsh) sb.delete();
    else if (push_m) sb.push_back({fl, d});
    if (drop_m) ovr_m = 1'b1;
    else if (clr) ovr_m = 1'b0;
    // idle tick count restarts on any activity or while nothing is buffered
    if (fsh || push_m || pop_m || sz == 0) begin
      idle = 0;
      if (fsh || pop_m) to_m = 1'b0;
    end else if (tk && idle < TO) begin
      idle++;
      if (idle == TO) to_m = 1'b1;
    end
    #1;
  endtask

  task automatic idle_cyc(input int n, input logic rr = 1'b0, input logic tk = 1'b0);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 3'b000, rr, tk);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    sb.delete(); ovr_m = 1'b0; to_m = 1'b0; idle = 0;
    #2;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout_irq), 32'd0);
    idle_cyc(2);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; thresh = '0;
    wr_en = 0; wr_data = 0; wr_parity_err = 0; wr_frame_err = 0; wr_break_err = 0;
    rd_ready = 0; sample_tick = 0; flush = 0; clr_overrun = 0;
    #1;
    apply_reset();

    // two characters read back in order with their flags
    step(1'b1, 8'h41, 3'b000, 1'b1, 1'b0);
    step(1'b1, 8'h42, 3'b010, 1'b1, 1'b0);
    idle_cyc(3, 1'b1);

    // overfill: 17th push dropped, overrun sticks until cleared
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 3'b000, 1'b0, 1'b0);
    idle_cyc(17, 1'b1);
    step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

    // push and pop together while full
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 3'(i), 1'b0, 1'b0);
    step(1'b1, 8'hA5, 3'b101, 1'b1, 1'b0);
    idle_cyc(17, 1'b1);

    // level interrupt threshold, then thresh = 0 disables it
    thresh = 5'd4;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i), 3'b000, 1'b0, 1'b0);
    step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
    thresh = 5'd0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 3'b001, 1'b0, 1'b0);
    idle_cyc(9, 1'b1);

    // timeout after 160 idle ticks; pop clears
    step(1'b1, 8'h77, 3'b000, 1'b0, 1'b0);
    idle_cyc(TO + 3, 1'b0, 1'b1);
    idle_cyc(1, 1'b1);
    // push landing on the 159th tick restarts the count
    step(1'b1, 8'h78, 3'b000, 1'b0, 1'b0);
    idle_cyc(TO - 2, 1'b0, 1'b1);
    step(1'b1, 8'h79, 3'b000, 1'b0, 1'b1);
    idle_cyc(TO - 2, 1'b0, 1'b1);
    idle_cyc(3, 1'b1);

    // flush with concurrent push/pop, overrun left set
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 3'b000, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 3'b000, 1'b1, 1'b0, 1'b1);
    idle_cyc(2, 1'b1);
    step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) thresh = 5'($urandom_range(0, 16));
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 99) < (i % 400 < 200 ? 35 : 70)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 29) == 0));
    end

    // reset mid-burst; first push afterwards is the first read
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i), 3'b111, 1'b0, 1'b0);
    apply_reset();
    step(1'b1, 8'h5A, 3'b100, 1'b0, 1'b0);
    step(1'b1, 8'h5B, 3'b000, 1'b0, 1'b0);
    idle_cyc(3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
